ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter WORD_LEN, default 32: instruction width.
REQ-002 Parameter EXE_CMD_LEN, default 4: ALU command width.
REQ-003 Parameter REG_ADDR_LEN, default 5: register-address width.
REQ-004 Parameter LOAD_USE_STALL, default 1, legal 1..3: bubbles inserted per load-use hazard.
REQ-005 Parameter SRA_EN, default 0: 1 enables SRA decode (funct 000011).
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 instruction  in  WORD_LEN  IF/ID instruction, decoded in ID.
REQ-009 freeze  in  1  external hold (memory busy); all state held.
REQ-010 br_eq  in  1  ID-stage rs==rt compare result.
REQ-011 pc_stall / ifid_stall  out  1 each  hold PC / IF-ID register.
REQ-012 if_flush  out  1  squash IF/ID (taken branch or jump).
REQ-013 branch_cmd  out  2  J=10, BEQ=11, BNE=01, else 00 (ID stage, combinational).
REQ-014 ex_cmd  out  EXE_CMD_LEN; ex_is_imm, ex_result_sel, ex_shift_dir  out  1 each  registered ID/EX control.
REQ-015 mem_read_en, mem_write_en  out  1 each  registered EX/MEM control.
REQ-016 wb_en  out  1; wb_dst  out  REG_ADDR_LEN  registered MEM/WB control.

Function
REQ-017 Decode SHALL use MIPS encodings: R-type ADD..NOR/SLT/SLTU (op 0, funct 10xxxx), SLL/SRL (and SRA when SRA_EN), imm ops op 001xxx, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
REQ-018 ex_cmd SHALL be funct[3:0] for R-type, op[29:26] for imm ops, 0 otherwise; ex_is_imm for imm/LW/SW/branch/J.
REQ-019 Destination SHALL be rd for R-type/shift, rt for imm/LW; wb_en=0 for SW, branch, J, all-zero instruction, and dst==0.
REQ-020 Control SHALL propagate ID->EX->MEM->WB one stage per unfrozen cycle; wb_en/wb_dst appear 3 cycles after ID.
REQ-021 Load-use hazard: EX holds LW with dst!=0 and dst equals ID rs, or ID rt when ID reads rt (R-type, SW, BEQ, BNE).
REQ-022 FSM states RUN, STALL; RUN->STALL on hazard; counter loads LOAD_USE_STALL-1; STALL->RUN when counter==0.
REQ-023 In STALL, and in the RUN cycle detecting hazard: pc_stall=ifid_stall=1, zero bubble into ID/EX, EX->MEM->WB keep advancing.
REQ-024 Hazard SHALL NOT be re-detected against the bubble; LW moves on, so one hazard yields exactly LOAD_USE_STALL bubbles.
REQ-025 Branch taken = J, BEQ&br_eq, or BNE&~br_eq; if_flush=1 for that one cycle only when not stalled and not frozen.
REQ-026 freeze=1: all pipeline registers, FSM and counter hold; pc_stall=ifid_stall=1; if_flush=0.
REQ-027 Priority: freeze > load-use stall > branch flush.

Reset
REQ-028 rst low SHALL immediately clear all pipeline registers and outputs to 0 and FSM to RUN, counter 0, including mid-stall.
REQ-029 First rising edge after rst deasserts SHALL decode normally.

Structure
REQ-030 Opcode/funct constants, branch_cmd codes and FSM state enum SHALL live in the shared defines package.
REQ-031 Combinational decode SHALL be sub-module ctrl_decode; ctrl_pipe owns registers, hazard FSM and flush.

Verification
REQ-032 ADD r3,r1,r2 (0x00221820) -> 3 cycles later wb_en=1, wb_dst=3; mem enables 0.
REQ-033 LW r2,0(r1) then ADD r3,r2,r4, LOAD_USE_STALL=2 -> pc_stall 2 cycles, two zero ID/EX bubbles, ADD reaches EX on cycle 3.
REQ-034 BEQ with br_eq=1 -> branch_cmd=11, if_flush one cycle; BNE with br_eq=1 -> if_flush=0.
REQ-035 Hazard and taken branch same cycle with freeze=1 -> all held, if_flush=0; release -> stall, then flush.
REQ-036 rst low mid-STALL -> all outputs 0 asynchronously; release, ORI r5 -> wb_en after 3 cycles, ex_cmd=1101.
REQ-037 SRA_EN=0, funct 000011 -> wb_en=0; SRA_EN=1 -> ex_result_sel=1, wb_en=1.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings for the pipeline controller: MIPS opcode/funct values,
// branch command codes, hazard FSM states and a branch-resolution helper.
package ctrl_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Immediate ALU ops share op[5:3]; R-type ALU ops share funct[5:4].
    localparam logic [2:0] OP_IMM_GRP = 3'b001;
    localparam logic [1:0] FN_ALU_GRP = 2'b10;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BNE  = 2'b01;
    localparam logic [1:0] BR_J    = 2'b10;
    localparam logic [1:0] BR_BEQ  = 2'b11;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Resolves whether the ID-stage branch command redirects fetch.
    function automatic logic br_taken(input logic [1:0] cmd, input logic eq);
        logic taken;
        case (cmd)
            BR_J:    taken = 1'b1;
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = ~eq;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Instruction/status bundle between the fetch side (master) and the
// pipeline controller (slave).
interface ctrl_pipe_if #(
    parameter int WORD_LEN     = 32,
    parameter int EXE_CMD_LEN  = 4,
    parameter int REG_ADDR_LEN = 5
);
    logic [WORD_LEN-1:0]     instruction;
    logic                    freeze;
    logic                    br_eq;
    logic                    pc_stall;
    logic                    ifid_stall;
    logic                    if_flush;
    logic [1:0]              branch_cmd;
    logic [EXE_CMD_LEN-1:0]  ex_cmd;
    logic                    ex_is_imm;
    logic                    ex_result_sel;
    logic                    ex_shift_dir;
    logic                    mem_read_en;
    logic                    mem_write_en;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_dst;

    modport master (
        output instruction, freeze, br_eq,
        input  pc_stall, ifid_stall, if_flush, branch_cmd,
        input  ex_cmd, ex_is_imm, ex_result_sel, ex_shift_dir,
        input  mem_read_en, mem_write_en, wb_en, wb_dst
    );

    modport slave (
        input  instruction, freeze, br_eq,
        output pc_stall, ifid_stall, if_flush, branch_cmd,
        output ex_cmd, ex_is_imm, ex_result_sel, ex_shift_dir,
        output mem_read_en, mem_write_en, wb_en, wb_dst
    );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Purely combinational ID-stage decode of one MIPS instruction word.
module ctrl_decode
    import ctrl_pipe_pkg::*;
#(
    parameter int WORD_LEN     = 32,
    parameter int EXE_CMD_LEN  = 4,
    parameter int REG_ADDR_LEN = 5,
    parameter int SRA_EN       = 0
) (
    input  logic [WORD_LEN-1:0]     instruction,
    output logic [1:0]              branch_cmd,
    output logic [EXE_CMD_LEN-1:0]  ex_cmd,
    output logic                    is_imm,
    output logic                    result_sel,
    output logic                    shift_dir,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    wb_en,
    output logic [REG_ADDR_LEN-1:0] wb_dst,
    output logic [REG_ADDR_LEN-1:0] rs,
    output logic [REG_ADDR_LEN-1:0] rt,
    output logic                    reads_rt
);
    logic [5:0]              op;
    logic [5:0]              funct;
    logic [REG_ADDR_LEN-1:0] rd;
    logic                    is_alu;
    logic                    is_shift;
    logic                    is_immop;
    logic                    is_lw;
    logic                    is_sw;
    logic                    is_beq;
    logic                    is_bne;
    logic                    is_j;
    logic                    unused_shamt;

    // The shift amount is consumed by the datapath, not by control.
    assign unused_shamt = ^instruction[10:6];

    // Classify the instruction and derive every ID-stage control field.
    always_comb begin
        op    = instruction[31:26];
        funct = instruction[5:0];
        rs    = REG_ADDR_LEN'(instruction[25:21]);
        rt    = REG_ADDR_LEN'(instruction[20:16]);
        rd    = REG_ADDR_LEN'(instruction[15:11]);

        is_alu   = (op == OP_RTYPE) && (funct[5:4] == FN_ALU_GRP);
        is_shift = (op == OP_RTYPE) &&
                   ((funct == FN_SLL) || (funct == FN_SRL) ||
                    ((SRA_EN != 0) && (funct == FN_SRA)));
        is_immop = (op[5:3] == OP_IMM_GRP);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_beq   = (op == OP_BEQ);
        is_bne   = (op == OP_BNE);
        is_j     = (op == OP_J);

        if (is_j)        branch_cmd = BR_J;
        else if (is_beq) branch_cmd = BR_BEQ;
        else if (is_bne) branch_cmd = BR_BNE;
        else             branch_cmd = BR_NONE;

        ex_cmd = '0;
        if (is_alu || is_shift) ex_cmd = EXE_CMD_LEN'(funct[3:0]);
        else if (is_immop)      ex_cmd = EXE_CMD_LEN'(op[3:0]);

        is_imm     = is_immop || is_lw || is_sw || is_beq || is_bne || is_j;
        result_sel = is_shift;
        // SRL and SRA both have funct[1] set; SLL does not.
        shift_dir  = is_shift && funct[1];
        mem_read   = is_lw;
        mem_write  = is_sw;

        if (is_alu || is_shift)    wb_dst = rd;
        else if (is_immop || is_lw) wb_dst = rt;
        else                        wb_dst = '0;

        wb_en    = (is_alu || is_shift || is_immop || is_lw) &&
                   (wb_dst != '0) && (instruction != '0);
        reads_rt = is_alu || is_shift || is_sw || is_beq || is_bne;
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline controller: ID/EX, EX/MEM and MEM/WB control registers, load-use
// stall FSM and branch flush. Decode is delegated to ctrl_decode.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_RUN   | normal issue; a load-use hazard here inserts the first bubble
// ST_STALL | extra bubbles; cnt_q = bubbles still owed including this one
//
// LOAD_USE_STALL (1..3) is the total bubble count per hazard. With a value
// of 1 the detecting RUN cycle is the only bubble and the FSM stays in RUN.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int WORD_LEN       = 32,
    parameter int EXE_CMD_LEN    = 4,
    parameter int REG_ADDR_LEN   = 5,
    parameter int LOAD_USE_STALL = 1,
    parameter int SRA_EN         = 0
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);
    localparam logic [1:0] STALL_RELOAD = 2'(LOAD_USE_STALL - 1);

    typedef struct packed {
        logic [EXE_CMD_LEN-1:0]  cmd;
        logic                    is_imm;
        logic                    result_sel;
        logic                    shift_dir;
        logic                    mem_read;
        logic                    mem_write;
        logic                    wb_en;
        logic [REG_ADDR_LEN-1:0] wb_dst;
    } idex_t;

    typedef struct packed {
        logic                    mem_read;
        logic                    mem_write;
        logic                    wb_en;
        logic [REG_ADDR_LEN-1:0] wb_dst;
    } exmem_t;

    typedef struct packed {
        logic                    wb_en;
        logic [REG_ADDR_LEN-1:0] wb_dst;
    } memwb_t;

    logic [1:0]              dec_branch_cmd;
    logic [EXE_CMD_LEN-1:0]  dec_cmd;
    logic                    dec_is_imm;
    logic                    dec_result_sel;
    logic                    dec_shift_dir;
    logic                    dec_mem_read;
    logic                    dec_mem_write;
    logic                    dec_wb_en;
    logic [REG_ADDR_LEN-1:0] dec_wb_dst;
    logic [REG_ADDR_LEN-1:0] dec_rs;
    logic [REG_ADDR_LEN-1:0] dec_rt;
    logic                    dec_reads_rt;

    idex_t     idex_q,  idex_d;
    exmem_t    exmem_q, exmem_d;
    memwb_t    memwb_q, memwb_d;
    hz_state_e state_q, state_d;
    logic [1:0] cnt_q,  cnt_d;

    logic hazard;
    logic stall_now;

    ctrl_decode #(
        .WORD_LEN     (WORD_LEN),
        .EXE_CMD_LEN  (EXE_CMD_LEN),
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .SRA_EN       (SRA_EN)
    ) u_decode (
        .instruction (bus.instruction),
        .branch_cmd  (dec_branch_cmd),
        .ex_cmd      (dec_cmd),
        .is_imm      (dec_is_imm),
        .result_sel  (dec_result_sel),
        .shift_dir   (dec_shift_dir),
        .mem_read    (dec_mem_read),
        .mem_write   (dec_mem_write),
        .wb_en       (dec_wb_en),
        .wb_dst      (dec_wb_dst),
        .rs          (dec_rs),
        .rt          (dec_rt),
        .reads_rt    (dec_reads_rt)
    );

    // Load-use detection against the load in EX; only RUN may start a stall,
    // so the bubble behind a load is never mistaken for a new hazard.
    always_comb begin
        hazard = idex_q.mem_read && idex_q.wb_en && (idex_q.wb_dst != '0) &&
                 ((idex_q.wb_dst == dec_rs) ||
                  (dec_reads_rt && (idex_q.wb_dst == dec_rt)));
        stall_now = (state_q == ST_STALL) || ((state_q == ST_RUN) && hazard);
    end

    // Next-state for pipeline registers and stall FSM; freeze holds everything.
    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.freeze) begin
            memwb_d.wb_en      = exmem_q.wb_en;
            memwb_d.wb_dst     = exmem_q.wb_dst;
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.wb_en      = idex_q.wb_en;
            exmem_d.wb_dst     = idex_q.wb_dst;
            if (stall_now) begin
                idex_d = '0;
            end else begin
                idex_d.cmd        = dec_cmd;
                idex_d.is_imm     = dec_is_imm;
                idex_d.result_sel = dec_result_sel;
                idex_d.shift_dir  = dec_shift_dir;
                idex_d.mem_read   = dec_mem_read;
                idex_d.mem_write  = dec_mem_write;
                idex_d.wb_en      = dec_wb_en;
                idex_d.wb_dst     = dec_wb_dst;
            end
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        cnt_d = STALL_RELOAD;
                        if (STALL_RELOAD != 2'd0) state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // All sequential state, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational outputs are gated by reset so they read 0 while it is held.
    assign bus.pc_stall      = rst & (bus.freeze | stall_now);
    assign bus.ifid_stall    = rst & (bus.freeze | stall_now);
    assign bus.if_flush      = rst & ~bus.freeze & ~stall_now &
                               br_taken(dec_branch_cmd, bus.br_eq);
    assign bus.branch_cmd    = rst ? dec_branch_cmd : BR_NONE;
    assign bus.ex_cmd        = idex_q.cmd;
    assign bus.ex_is_imm     = idex_q.is_imm;
    assign bus.ex_result_sel = idex_q.result_sel;
    assign bus.ex_shift_dir  = idex_q.shift_dir;
    assign bus.mem_read_en   = exmem_q.mem_read;
    assign bus.mem_write_en  = exmem_q.mem_write;
    assign bus.wb_en         = memwb_q.wb_en;
    assign bus.wb_dst        = memwb_q.wb_dst;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe. Instance A uses LOAD_USE_STALL=2/SRA_EN=1,
// instance B the defaults; both see the same instruction stream.
module tb_ctrl_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5)) bus_a ();
    ctrl_pipe_if #(.WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5)) bus_b ();

    ctrl_pipe #(
        .WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5),
        .LOAD_USE_STALL(2), .SRA_EN(1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    ctrl_pipe #(
        .WORD_LEN(32), .EXE_CMD_LEN(4), .REG_ADDR_LEN(5),
        .LOAD_USE_STALL(1), .SRA_EN(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    localparam logic [31:0] I_NOP    = 32'h0000_0000;
    localparam logic [31:0] I_ADD    = 32'h0022_1820; // add r3,r1,r2
    localparam logic [31:0] I_OR     = 32'h0044_1825; // or  r3,r2,r4
    localparam logic [31:0] I_LW     = 32'h8C22_0000; // lw  r2,0(r1)
    localparam logic [31:0] I_SW     = 32'hAC22_0004; // sw  r2,4(r1)
    localparam logic [31:0] I_BEQ    = 32'h1022_0004; // beq r1,r2
    localparam logic [31:0] I_BNE    = 32'h1422_0004; // bne r1,r2
    localparam logic [31:0] I_J      = 32'h0800_0010; // j
    localparam logic [31:0] I_BEQ_HZ = 32'h1041_0004; // beq r2,r1
    localparam logic [31:0] I_ORI    = 32'h3405_0012; // ori r5,r0,0x12
    localparam logic [31:0] I_SRA    = 32'h0002_30C3; // sra r6,r2,3

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic frz, input logic eq);
        bus_a.instruction = instr;
        bus_a.freeze      = frz;
        bus_a.br_eq       = eq;
        bus_b.instruction = instr;
        bus_b.freeze      = frz;
        bus_b.br_eq       = eq;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        drive(I_NOP, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        drive(I_NOP, 1'b1, 1'b0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_eq("rst_pc_stall", bus_a.pc_stall, 0);
        chk_eq("rst_wb_en",    bus_a.wb_en,    0);
        chk_eq("rst_ex_cmd",   bus_a.ex_cmd,   0);

        @(negedge clk);
        drive(I_NOP, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // ADD r3,r1,r2 flows to writeback three cycles later
        drive(I_ADD, 1'b0, 1'b0); #1;
        chk_eq("add_brcmd", bus_a.branch_cmd, 0);
        chk_eq("add_stall", bus_a.pc_stall, 0);
        tick();
        drive(I_NOP, 1'b0, 1'b0); #1;
        chk_eq("add_ex_imm", bus_a.ex_is_imm, 0);
        tick(); #1;
        chk_eq("add_mem_rd", bus_a.mem_read_en, 0);
        chk_eq("add_mem_wr", bus_a.mem_write_en, 0);
        tick(); #1;
        chk_eq("add_wb_en",  bus_a.wb_en, 1);
        chk_eq("add_wb_dst", bus_a.wb_dst, 3);

        // SW: immediate, memory write, no writeback
        drive(I_SW, 1'b0, 1'b0);
        tick();
        drive(I_NOP, 1'b0, 1'b0); #1;
        chk_eq("sw_ex_imm", bus_a.ex_is_imm, 1);
        tick(); #1;
        chk_eq("sw_mem_wr", bus_a.mem_write_en, 1);
        tick(); #1;
        chk_eq("sw_wb_en", bus_a.wb_en, 0);
        drain();

        // Load-use: LW r2 then OR r3,r2,r4
        drive(I_LW, 1'b0, 1'b0); #1;
        chk_eq("lu_pre_stall", bus_a.pc_stall, 0);
        tick();
        drive(I_OR, 1'b0, 1'b0); #1;
        chk_eq("lu_a_stall1",  bus_a.pc_stall, 1);
        chk_eq("lu_a_ifid1",   bus_a.ifid_stall, 1);
        chk_eq("lu_b_stall1",  bus_b.pc_stall, 1);
        tick(); #1;
        chk_eq("lu_a_stall2",  bus_a.pc_stall, 1);
        chk_eq("lu_a_bub1",    bus_a.ex_cmd, 0);
        chk_eq("lu_a_bub1imm", bus_a.ex_is_imm, 0);
        chk_eq("lu_a_memrd",   bus_a.mem_read_en, 1);
        chk_eq("lu_b_run",     bus_b.pc_stall, 0);
        tick(); #1;
        chk_eq("lu_a_stall3",  bus_a.pc_stall, 0);
        chk_eq("lu_a_bub2",    bus_a.ex_cmd, 0);
        chk_eq("lu_a_wb_en",   bus_a.wb_en, 1);
        chk_eq("lu_a_wb_dst",  bus_a.wb_dst, 2);
        chk_eq("lu_b_or_ex",   bus_b.ex_cmd, 4'b0101);
        tick(); #1;
        chk_eq("lu_a_or_ex",   bus_a.ex_cmd, 4'b0101);
        drain();

        // Branches
        drive(I_BEQ, 1'b0, 1'b1); #1;
        chk_eq("beq_cmd",   bus_a.branch_cmd, 2'b11);
        chk_eq("beq_flush", bus_a.if_flush, 1);
        tick();
        drive(I_NOP, 1'b0, 1'b1); #1;
        chk_eq("nop_flush", bus_a.if_flush, 0);
        tick();
        drive(I_BNE, 1'b0, 1'b1); #1;
        chk_eq("bne_cmd",   bus_a.branch_cmd, 2'b01);
        chk_eq("bne_eq_flush", bus_a.if_flush, 0);
        tick();
        drive(I_BNE, 1'b0, 1'b0); #1;
        chk_eq("bne_ne_flush", bus_a.if_flush, 1);
        tick();
        drive(I_J, 1'b0, 1'b0); #1;
        chk_eq("j_cmd",   bus_a.branch_cmd, 2'b10);
        chk_eq("j_flush", bus_a.if_flush, 1);
        tick();
        drain();

        // Hazard plus taken branch under freeze, then release
        drive(I_LW, 1'b0, 1'b0);
        tick();
        drive(I_BEQ_HZ, 1'b1, 1'b1); #1;
        chk_eq("frz_stall",  bus_a.pc_stall, 1);
        chk_eq("frz_flush",  bus_a.if_flush, 0);
        chk_eq("frz_ex_lw",  bus_a.ex_is_imm, 1);
        tick(); #1;
        chk_eq("frz_hold_ex",  bus_a.ex_is_imm, 1);
        chk_eq("frz_hold_mem", bus_a.mem_read_en, 0);
        drive(I_BEQ_HZ, 1'b0, 1'b1); #1;
        chk_eq("rel_stall", bus_a.pc_stall, 1);
        chk_eq("rel_flush", bus_a.if_flush, 0);
        tick(); #1;
        chk_eq("rel_stall2", bus_a.pc_stall, 1);
        chk_eq("rel_flush2", bus_a.if_flush, 0);
        chk_eq("rel_bubble", bus_a.ex_is_imm, 0);
        chk_eq("rel_mem_lw", bus_a.mem_read_en, 1);
        tick(); #1;
        chk_eq("rel_run",    bus_a.pc_stall, 0);
        chk_eq("rel_flush3", bus_a.if_flush, 1);
        drain();

        // Reset in the middle of a stall
        drive(I_LW, 1'b0, 1'b0);
        tick();
        drive(I_OR, 1'b0, 1'b0);
        tick(); #1;
        chk_eq("mid_stall",  bus_a.pc_stall, 1);
        chk_eq("mid_mem_lw", bus_a.mem_read_en, 1);
        #2 rst = 1'b0;
        #1;
        chk_eq("arst_stall",  bus_a.pc_stall, 0);
        chk_eq("arst_ifid",   bus_a.ifid_stall, 0);
        chk_eq("arst_mem_rd", bus_a.mem_read_en, 0);
        drive(I_ORI, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; #1;
        chk_eq("ori_stall", bus_a.pc_stall, 0);
        tick(); #1;
        chk_eq("ori_ex_cmd", bus_a.ex_cmd, 4'b1101);
        chk_eq("ori_ex_imm", bus_a.ex_is_imm, 1);
        drive(I_NOP, 1'b0, 1'b0);
        tick();
        tick(); #1;
        chk_eq("ori_wb_en",  bus_a.wb_en, 1);
        chk_eq("ori_wb_dst", bus_a.wb_dst, 5);

        // SRA decode with and without SRA_EN
        drive(I_SRA, 1'b0, 1'b0);
        tick();
        drive(I_NOP, 1'b0, 1'b0); #1;
        chk_eq("sra_a_sel", bus_a.ex_result_sel, 1);
        chk_eq("sra_a_dir", bus_a.ex_shift_dir, 1);
        chk_eq("sra_a_cmd", bus_a.ex_cmd, 4'b0011);
        chk_eq("sra_b_sel", bus_b.ex_result_sel, 0);
        tick();
        tick(); #1;
        chk_eq("sra_a_wb_en",  bus_a.wb_en, 1);
        chk_eq("sra_a_wb_dst", bus_a.wb_dst, 6);
        chk_eq("sra_b_wb_en",  bus_b.wb_en, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
